// File: rtl/mod_n_updown_counter.sv
// mod_n_updown_counter: parametrised modulo-N up/down counter with load,
// side-by-side Mealy/Moore terminal count, registered wrap and load-error flags.
`default_nettype none

module mod_n_updown_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] next_count,
  output logic             tc_moore,
  output logic             tc_mealy,
  output logic             wrap,
  output logic             load_err
);

  // One extra bit so MODULUS == 2^WIDTH is representable in range compares.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO    = '0;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;

  logic legal;
  logic load_ok;
  logic at_last;
  logic at_zero;
  logic mealy;

  always_comb begin
    legal   = ({1'b0, count_q} < MOD_EXT);
    load_ok = ({1'b0, load_val} < MOD_EXT);
    at_last = (count_q == LAST);
    at_zero = (count_q == ZERO);

    count_d = count_q;
    if (!legal) begin
      count_d = ZERO;
    end else if (load) begin
      count_d = load_ok ? load_val : ZERO;
    end else if (en) begin
      if (up) begin
        count_d = at_last ? ZERO : (count_q + ONE);
      end else begin
        count_d = at_zero ? LAST : (count_q - ONE);
      end
    end

    mealy      = en & ~load & legal & ((up & at_last) | (~up & at_zero));
    wrap_d     = mealy;
    load_err_d = load & ~load_ok;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= ZERO;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count      = count_q;
  assign next_count = count_d;
  // at_last alone is never true in an illegal state, so no legal gating needed.
  assign tc_moore   = at_last;
  assign tc_mealy   = mealy;
  assign wrap       = wrap_q;
  assign load_err   = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_n_updown_counter.sv
// Testbench for mod_n_updown_counter: scenario tasks against a modulo-arithmetic
// reference model, on a 3/5, a 4/16 and a 4/10 instance.
`default_nettype none

module tb_mod_n_updown_counter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Main instance WIDTH=3, MODULUS=5
  logic       en, up, load;
  logic [2:0] lv;
  logic [2:0] count, next_count;
  logic       tc_moore, tc_mealy, wrap, load_err;

  // WIDTH=4, MODULUS=16
  logic       en16, up16, load16;
  logic [3:0] lv16;
  logic [3:0] count16, next16;
  logic       tcmo16, tcme16, wrap16, lerr16;

  // WIDTH=4, MODULUS=10
  logic       en10, up10, load10;
  logic [3:0] lv10;
  logic [3:0] count10, next10;
  logic       tcmo10, tcme10, wrap10, lerr10;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state for the main instance
  int mc;
  bit mw, mle;

  mod_n_updown_counter #(.WIDTH(3), .MODULUS(5)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv),
    .count(count), .next_count(next_count), .tc_moore(tc_moore),
    .tc_mealy(tc_mealy), .wrap(wrap), .load_err(load_err)
  );

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .reset(reset), .en(en16), .up(up16), .load(load16), .load_val(lv16),
    .count(count16), .next_count(next16), .tc_moore(tcmo16),
    .tc_mealy(tcme16), .wrap(wrap16), .load_err(lerr16)
  );

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk(clk), .reset(reset), .en(en10), .up(up10), .load(load10), .load_val(lv10),
    .count(count10), .next_count(next10), .tc_moore(tcmo10),
    .tc_mealy(tcme10), .wrap(wrap10), .load_err(lerr10)
  );

  // Reference rules expressed as modulo arithmetic on plain integers.
  function automatic int f_next(int c, int m, bit e, bit u, bit l, int v);
    if (c >= m) return 0;
    if (l) return (v < m) ? v : 0;
    if (e) return u ? (c + 1) % m : (c + m - 1) % m;
    return c;
  endfunction

  function automatic bit f_wraps(int c, int m, bit e, bit u, bit l);
    if (c >= m || l || !e) return 1'b0;
    return u ? (c + 1 >= m) : (c - 1 < 0);
  endfunction

  // Clock one edge on the main instance and advance the model alongside.
  task automatic advance();
    int nc;
    bit nw, nle;
    nc  = f_next(mc, 5, en, up, load, int'(lv));
    nw  = f_wraps(mc, 5, en, up, load);
    nle = load && (int'(lv) >= 5);
    @(posedge clk);
    #1;
    mc  = nc;
    mw  = nw;
    mle = nle;
  endtask

  task automatic set_in(bit e, bit u, bit l, int v);
    en = e; up = u; load = l; lv = 3'(v);
  endtask

  task automatic test_reset();
    n_checks++;
    if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++;
    if (wrap !== 1'b0 || load_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: wrap=%b load_err=%b want 0 0", wrap, load_err);
    end
    n_checks++;
    if (tc_moore !== 1'b0 || next_count !== 3'd0 || tc_mealy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_comb: tc_moore=%b next=%0d tc_mealy=%b want 0 0 0", tc_moore, next_count, tc_mealy);
    end
  endtask

  task automatic test_up_count();
    int exp_seq[12] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};
    bit exp_wrap;
    exp_wrap = 1'b0;
    set_in(1, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      #1;
      n_checks++;
      if (count !== 3'(exp_seq[i]) || wrap !== exp_wrap) begin
        n_fail++;
        $display("FAIL up_seq[%0d]: count=%0d wrap=%b want %0d %b", i, count, wrap, exp_seq[i], exp_wrap);
      end
      n_checks++;
      if (tc_moore !== (exp_seq[i] == 4) || tc_mealy !== (exp_seq[i] == 4)) begin
        n_fail++;
        $display("FAIL up_tc[%0d]: tc_moore=%b tc_mealy=%b want %b %b", i, tc_moore, tc_mealy,
                 exp_seq[i] == 4, exp_seq[i] == 4);
      end
      exp_wrap = (exp_seq[i] == 4);
      advance();
    end
  endtask

  task automatic test_down_count();
    int exp_seq[7] = '{0, 4, 3, 2, 1, 0, 4};
    bit exp_wrap;
    set_in(0, 0, 1, 0);
    advance();
    exp_wrap = 1'b0;
    set_in(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      #1;
      n_checks++;
      if (count !== 3'(exp_seq[i]) || wrap !== exp_wrap) begin
        n_fail++;
        $display("FAIL down_seq[%0d]: count=%0d wrap=%b want %0d %b", i, count, wrap, exp_seq[i], exp_wrap);
      end
      n_checks++;
      if (tc_moore !== (exp_seq[i] == 4) || tc_mealy !== (exp_seq[i] == 0)) begin
        n_fail++;
        $display("FAIL down_tc[%0d]: tc_moore=%b tc_mealy=%b want %b %b", i, tc_moore, tc_mealy,
                 exp_seq[i] == 4, exp_seq[i] == 0);
      end
      exp_wrap = (exp_seq[i] == 0);
      advance();
    end
  endtask

  task automatic test_load();
    set_in(0, 0, 1, 2);
    advance();
    n_checks++;
    if (count !== 3'd2) begin n_fail++; $display("FAIL load_2: count=%0d want 2", count); end
    set_in(1, 1, 1, 3);
    advance();
    n_checks++;
    if (count !== 3'd3 || wrap !== 1'b0 || load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL load_3: count=%0d wrap=%b load_err=%b want 3 0 0", count, wrap, load_err);
    end
    // Load at the terminal count with en high must not produce a wrap.
    set_in(0, 0, 1, 4);
    advance();
    set_in(1, 1, 1, 1);
    #1;
    n_checks++;
    if (tc_mealy !== 1'b0 || tc_moore !== 1'b1 || next_count !== 3'd1) begin
      n_fail++;
      $display("FAIL load_at_tc: tc_mealy=%b tc_moore=%b next=%0d want 0 1 1", tc_mealy, tc_moore, next_count);
    end
    advance();
    n_checks++;
    if (count !== 3'd1 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL load_at_tc_edge: count=%0d wrap=%b want 1 0", count, wrap);
    end
    set_in(1, 1, 1, 6);
    advance();
    n_checks++;
    if (count !== 3'd0 || load_err !== 1'b1) begin
      n_fail++; $display("FAIL load_oob: count=%0d load_err=%b want 0 1", count, load_err);
    end
    set_in(0, 1, 0, 0);
    advance();
    n_checks++;
    if (load_err !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL load_err_pulse: load_err=%b count=%0d want 0 0", load_err, count);
    end
  endtask

  task automatic test_hold();
    set_in(0, 0, 1, 4);
    advance();
    set_in(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      advance();
      n_checks++;
      if (count !== 3'd4 || tc_moore !== 1'b1 || tc_mealy !== 1'b0 || wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: count=%0d tc_moore=%b tc_mealy=%b wrap=%b want 4 1 0 0",
                 i, count, tc_moore, tc_mealy, wrap);
      end
    end
    set_in(1, 0, 0, 0);
    advance();
    n_checks++;
    if (count !== 3'd3 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: count=%0d wrap=%b want 3 0", count, wrap);
    end
  endtask

  task automatic test_async_reset();
    set_in(0, 0, 1, 3);
    advance();
    set_in(1, 1, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (count !== 3'd0 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: count=%0d wrap=%b want 0 0 before edge", count, wrap);
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    mc = 0; mw = 1'b0; mle = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (count !== 3'd1 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL async_release: count=%0d wrap=%b want 1 0", count, wrap);
    end
    mc = 1;
  endtask

  task automatic test_random();
    bit e, u, l;
    int v;
    for (int i = 0; i < 300; i++) begin
      e = 1'($urandom_range(0, 3) != 0);
      u = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 7) == 0);
      v = $urandom_range(0, 7);
      set_in(e, u, l, v);
      #1;
      n_checks++;
      if (count !== 3'(mc) || next_count !== 3'(f_next(mc, 5, e, u, l, v)) ||
          tc_mealy !== f_wraps(mc, 5, e, u, l) || tc_moore !== (mc == 4)) begin
        n_fail++;
        $display("FAIL rand_comb[%0d]: count=%0d next=%0d mealy=%b moore=%b want %0d %0d %b %b", i,
                 count, next_count, tc_mealy, tc_moore, mc, f_next(mc, 5, e, u, l, v),
                 f_wraps(mc, 5, e, u, l), mc == 4);
      end
      advance();
      n_checks++;
      if (count !== 3'(mc) || wrap !== mw || load_err !== mle) begin
        n_fail++;
        $display("FAIL rand_edge[%0d]: count=%0d wrap=%b load_err=%b want %0d %b %b", i,
                 count, wrap, load_err, mc, mw, mle);
      end
    end
  endtask

  task automatic test_full_range();
    int  c;
    bit  w, nw;
    int  wraps;
    en16 = 1'b0; up16 = 1'b1; load16 = 1'b1; lv16 = 4'd13;
    @(posedge clk); #1;
    c = 13; w = 1'b0; wraps = 0;
    en16 = 1'b1; load16 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if (count16 !== 4'(c) || wrap16 !== w || tcme16 !== (c == 15)) begin
        n_fail++;
        $display("FAIL m16[%0d]: count=%0d wrap=%b mealy=%b want %0d %b %b", i, count16, wrap16, tcme16,
                 c, w, c == 15);
      end
      if (w) wraps++;
      nw = f_wraps(c, 16, 1'b1, 1'b1, 1'b0);
      c  = f_next(c, 16, 1'b1, 1'b1, 1'b0, 0);
      w  = nw;
      @(posedge clk); #1;
    end
    n_checks++;
    if (wraps !== 1) begin n_fail++; $display("FAIL m16_wrap_count: got %0d want 1", wraps); end
    en16 = 1'b0;
  endtask

  task automatic test_illegal();
    en10 = 1'b1; up10 = 1'b1; load10 = 1'b1; lv10 = 4'd9;
    @(posedge clk); #1;
    load10 = 1'b0;
    force dut10.count_q = 4'd12;
    #1;
    n_checks++;
    if (count10 !== 4'd12 || tcmo10 !== 1'b0 || tcme10 !== 1'b0 || next10 !== 4'd0) begin
      n_fail++;
      $display("FAIL m10_illegal: count=%0d moore=%b mealy=%b next=%0d want 12 0 0 0",
               count10, tcmo10, tcme10, next10);
    end
    release dut10.count_q;
    @(posedge clk); #1;
    n_checks++;
    if (count10 !== 4'd0 || wrap10 !== 1'b0 || tcmo10 !== 1'b0) begin
      n_fail++;
      $display("FAIL m10_recover: count=%0d wrap=%b moore=%b want 0 0 0", count10, wrap10, tcmo10);
    end
    en10 = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0);
    en16 = 1'b0; up16 = 1'b0; load16 = 1'b0; lv16 = '0;
    en10 = 1'b0; up10 = 1'b0; load10 = 1'b0; lv10 = '0;
    mc = 0; mw = 1'b0; mle = 1'b0;
    #12;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_up_count();
    test_down_count();
    test_load();
    test_hold();
    test_async_reset();
    test_random();
    test_full_range();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
